// File: rtl/mem_stage.sv
// Memory pipeline stage: issues loads/stores on the data bus, aligns load data and registers WB fields.
// Optional feature macro: MEM_ADEX_EN (address-error detection for misaligned half/word accesses).
module mem_stage #(
    parameter int MMOP_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mm_flush_i,
    input  logic              mm_stall_i,
    input  logic              mm_wren_i,
    input  logic [4:0]        mm_waddr_i,
    input  logic [31:0]       mm_wdata_i,
    input  logic [31:0]       mm_stdata_i,
    input  logic [MMOP_W-1:0] mm_memop_i,
    input  logic [31:0]       mm_inst_i,
    input  logic              mm_inslot_i,
    input  logic              mm_nofwd_i,
    output logic              data_req_o,
    output logic              data_wr_o,
    output logic [1:0]        data_size_o,
    output logic [3:0]        data_wstrb_o,
    output logic [31:0]       data_addr_o,
    output logic [31:0]       data_wdata_o,
    input  logic              data_addr_ok_i,
    input  logic              data_data_ok_i,
    input  logic [31:0]       data_rdata_i,
    output logic              wb_wren_o,
    output logic [4:0]        wb_waddr_o,
    output logic [31:0]       wb_wdata_o,
    output logic [31:0]       wb_inst_o,
    output logic              wb_inslot_o,
    output logic [31:0]       mm_wdata_bp_o,
    output logic              mm_nofwd_o,
    output logic              mm_stallreq_o,
    output logic              mm_excp_o
);

    localparam logic [MMOP_W-1:0] OP_LB  = MMOP_W'(1);
    localparam logic [MMOP_W-1:0] OP_LBU = MMOP_W'(2);
    localparam logic [MMOP_W-1:0] OP_LH  = MMOP_W'(3);
    localparam logic [MMOP_W-1:0] OP_LHU = MMOP_W'(4);
    localparam logic [MMOP_W-1:0] OP_LW  = MMOP_W'(5);
    localparam logic [MMOP_W-1:0] OP_SB  = MMOP_W'(6);
    localparam logic [MMOP_W-1:0] OP_SH  = MMOP_W'(7);
    localparam logic [MMOP_W-1:0] OP_SW  = MMOP_W'(8);

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_DONE, S_CANCEL} state_e;

    state_e      state_q, state_d;
    logic [31:0] buf_q;
    logic        is_load, is_store, adex, mem_go, req;
    logic [1:0]  size;
    logic [3:0]  strb;
    logic [31:0] st_wdata;
    logic        result_ready;
    logic [31:0] raw_rdata, load_res;

    logic        wb_wren_q, wb_inslot_q;
    logic [4:0]  wb_waddr_q;
    logic [31:0] wb_wdata_q, wb_inst_q;

    function automatic logic [31:0] load_extract(input logic [MMOP_W-1:0] op,
                                                 input logic [1:0] a,
                                                 input logic [31:0] w);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        b = w[8*a +: 8];
        h = a[1] ? w[31:16] : w[15:0];
        case (op)
            OP_LB:   load_extract = 32'(b);
            OP_LBU:  load_extract = {24'd0, b};
            OP_LH:   load_extract = 32'(h);
            OP_LHU:  load_extract = {16'd0, h};
            default: load_extract = w;
        endcase
    endfunction

    always_comb begin
        is_load  = 1'b0;
        is_store = 1'b0;
        size     = 2'd2;
        strb     = 4'b0000;
        st_wdata = mm_stdata_i;
        case (mm_memop_i)
            OP_LB, OP_LBU: begin is_load = 1'b1; size = 2'd0; end
            OP_LH, OP_LHU: begin is_load = 1'b1; size = 2'd1; end
            OP_LW:         begin is_load = 1'b1; size = 2'd2; end
            OP_SB: begin
                is_store = 1'b1;
                size     = 2'd0;
                strb     = 4'b0001 << mm_wdata_i[1:0];
                st_wdata = {4{mm_stdata_i[7:0]}};
            end
            OP_SH: begin
                is_store = 1'b1;
                size     = 2'd1;
                strb     = 4'b0011 << {mm_wdata_i[1], 1'b0};
                st_wdata = {2{mm_stdata_i[15:0]}};
            end
            OP_SW: begin
                is_store = 1'b1;
                size     = 2'd2;
                strb     = 4'b1111;
            end
            default: ;
        endcase
    end

`ifdef MEM_ADEX_EN
    assign adex = (is_load | is_store) &
                  (((size == 2'd1) & mm_wdata_i[0]) | ((size == 2'd2) & (|mm_wdata_i[1:0])));
`else
    assign adex = 1'b0;
`endif

    assign mem_go = (is_load | is_store) & ~adex;

    // Bus handshake FSM: one transaction outstanding at most
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        req     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (mem_go & ~mm_flush_i) begin
                    req     = 1'b1;
                    state_d = data_addr_ok_i ? S_WAIT : S_REQ;
                end
            end
            S_REQ: begin
                if (mm_flush_i) begin
                    state_d = S_IDLE;
                end else begin
                    req = 1'b1;
                    if (data_addr_ok_i) state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (data_data_ok_i)  state_d = (mm_flush_i | ~mm_stall_i) ? S_IDLE : S_DONE;
                else if (mm_flush_i) state_d = S_CANCEL;
            end
            S_DONE: begin
                if (mm_flush_i | ~mm_stall_i) state_d = S_IDLE;
            end
            S_CANCEL: begin
                if (data_data_ok_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Holds load data while the pipeline is stalled after the response
    always_ff @(posedge clk) begin
        if ((state_q == S_WAIT) && data_data_ok_i) buf_q <= data_rdata_i;
    end

    assign result_ready = ((state_q == S_WAIT) & data_data_ok_i) | (state_q == S_DONE);
    assign raw_rdata    = (state_q == S_DONE) ? buf_q : data_rdata_i;
    assign load_res     = load_extract(mm_memop_i, mm_wdata_i[1:0], raw_rdata);

    assign data_req_o    = req;
    assign data_wr_o     = is_store;
    assign data_size_o   = size;
    assign data_wstrb_o  = strb;
    assign data_addr_o   = mm_wdata_i;
    assign data_wdata_o  = st_wdata;

    assign mm_stallreq_o = mem_go & ~result_ready;
    assign mm_nofwd_o    = mm_nofwd_i | (is_load & ~adex & ~result_ready);
    assign mm_wdata_bp_o = (is_load & result_ready) ? load_res : mm_wdata_i;

    // MEM/WB boundary
    always_ff @(posedge clk or posedge rst) begin
        if (rst || mm_flush_i) begin
            wb_wren_q   <= 1'b0;
            wb_waddr_q  <= 5'd0;
            wb_wdata_q  <= 32'd0;
            wb_inst_q   <= 32'd0;
            wb_inslot_q <= 1'b0;
        end else if (!mm_stall_i) begin
            wb_wren_q   <= mm_wren_i & ~is_store & ~adex;
            wb_waddr_q  <= mm_waddr_i;
            wb_wdata_q  <= is_load ? load_res : mm_wdata_i;
            wb_inst_q   <= mm_inst_i;
            wb_inslot_q <= mm_inslot_i;
        end
    end

`ifdef MEM_ADEX_EN
    logic excp_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst || mm_flush_i) excp_q <= 1'b0;
        else if (!mm_stall_i)  excp_q <= adex;
    end
    assign mm_excp_o = excp_q;
`else
    assign mm_excp_o = 1'b0;
`endif

    assign wb_wren_o   = wb_wren_q;
    assign wb_waddr_o  = wb_waddr_q;
    assign wb_wdata_o  = wb_wdata_q;
    assign wb_inst_o   = wb_inst_q;
    assign wb_inslot_o = wb_inslot_q;

endmodule

// File: tb/tb_mem_stage.sv
// Testbench for mem_stage: directed scenarios plus randomized load/store traffic against a behavioural model.
module tb_mem_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic        mm_flush_i, mm_stall_i, ext_stall;
    logic        mm_wren_i, mm_inslot_i, mm_nofwd_i;
    logic [4:0]  mm_waddr_i;
    logic [31:0] mm_wdata_i, mm_stdata_i, mm_inst_i;
    logic [3:0]  mm_memop_i;
    logic        data_req_o, data_wr_o;
    logic [1:0]  data_size_o;
    logic [3:0]  data_wstrb_o;
    logic [31:0] data_addr_o, data_wdata_o;
    logic        data_addr_ok_i, data_data_ok_i;
    logic [31:0] data_rdata_i;
    logic        wb_wren_o, wb_inslot_o;
    logic [4:0]  wb_waddr_o;
    logic [31:0] wb_wdata_o, wb_inst_o, mm_wdata_bp_o;
    logic        mm_nofwd_o, mm_stallreq_o, mm_excp_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // The controller stalls the pipeline whenever the stage asks for it
    assign mm_stall_i = ext_stall | mm_stallreq_o;

    mem_stage #(.MMOP_W(4)) dut (
        .clk(clk), .rst(rst), .mm_flush_i(mm_flush_i), .mm_stall_i(mm_stall_i),
        .mm_wren_i(mm_wren_i), .mm_waddr_i(mm_waddr_i), .mm_wdata_i(mm_wdata_i),
        .mm_stdata_i(mm_stdata_i), .mm_memop_i(mm_memop_i), .mm_inst_i(mm_inst_i),
        .mm_inslot_i(mm_inslot_i), .mm_nofwd_i(mm_nofwd_i),
        .data_req_o(data_req_o), .data_wr_o(data_wr_o), .data_size_o(data_size_o),
        .data_wstrb_o(data_wstrb_o), .data_addr_o(data_addr_o), .data_wdata_o(data_wdata_o),
        .data_addr_ok_i(data_addr_ok_i), .data_data_ok_i(data_data_ok_i), .data_rdata_i(data_rdata_i),
        .wb_wren_o(wb_wren_o), .wb_waddr_o(wb_waddr_o), .wb_wdata_o(wb_wdata_o),
        .wb_inst_o(wb_inst_o), .wb_inslot_o(wb_inslot_o), .mm_wdata_bp_o(mm_wdata_bp_o),
        .mm_nofwd_o(mm_nofwd_o), .mm_stallreq_o(mm_stallreq_o), .mm_excp_o(mm_excp_o)
    );

    // ---------------- reference model ----------------
    function automatic bit m_is_load(input logic [3:0] op);
        return (op >= 4'd1) && (op <= 4'd5);
    endfunction

    function automatic bit m_is_store(input logic [3:0] op);
        return (op >= 4'd6) && (op <= 4'd8);
    endfunction

    function automatic logic [31:0] m_load(input logic [3:0] op, input logic [31:0] a, input logic [31:0] d);
        logic [31:0] v;
        case (op)
            4'd1, 4'd2: begin
                v = (d >> (8 * (a % 4))) & 32'hFF;
                if (op == 4'd1 && v >= 32'd128) v = v + 32'hFFFF_FF00;
            end
            4'd3, 4'd4: begin
                v = (d >> (16 * ((a / 2) % 2))) & 32'hFFFF;
                if (op == 4'd3 && v >= 32'h8000) v = v + 32'hFFFF_0000;
            end
            default: v = d;
        endcase
        return v;
    endfunction

    function automatic logic [1:0] m_size(input logic [3:0] op);
        case (op)
            4'd1, 4'd2, 4'd6: return 2'd0;
            4'd3, 4'd4, 4'd7: return 2'd1;
            default:          return 2'd2;
        endcase
    endfunction

    function automatic logic [3:0] m_strb(input logic [3:0] op, input logic [31:0] a);
        case (op)
            4'd6:    return 4'(1 << (a % 4));
            4'd7:    return 4'(3 << (2 * ((a / 2) % 2)));
            4'd8:    return 4'hF;
            default: return 4'h0;
        endcase
    endfunction

    function automatic logic [31:0] m_wdata(input logic [3:0] op, input logic [31:0] s);
        case (op)
            4'd6:    return (s & 32'hFF) * 32'h0101_0101;
            4'd7:    return (s & 32'hFFFF) * 32'h0001_0001;
            default: return s;
        endcase
    endfunction

    // Presents one instruction and plays the bus: addr_ok after aok_d cycles, data_ok dok_d cycles after accept
    task automatic run_op(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] st,
                          input logic [31:0] rd, input int aok_d, input int dok_d);
        logic [31:0] exp_wd, inst;
        logic [4:0]  wa;
        logic        wren, slot, nf, exp_wren;
        bit          ld, stv, memv, accepted, done;
        int          cyc, acc_cyc, nreq;
        wa = 5'($urandom); inst = $urandom; wren = 1'($urandom); slot = 1'($urandom); nf = 1'($urandom);
        ld = m_is_load(op); stv = m_is_store(op); memv = ld | stv;
        exp_wd   = ld ? m_load(op, addr, rd) : addr;
        exp_wren = wren & ~stv;
        mm_memop_i = op; mm_wdata_i = addr; mm_stdata_i = st; mm_waddr_i = wa; mm_inst_i = inst;
        mm_wren_i = wren; mm_inslot_i = slot; mm_nofwd_i = nf; mm_flush_i = 1'b0; ext_stall = 1'b0;
        accepted = 0; done = 0; cyc = 0; acc_cyc = 0; nreq = 0;
        while (!done && cyc < 40) begin
            data_addr_ok_i = memv && !accepted && (cyc >= aok_d);
            data_data_ok_i = accepted && (cyc == acc_cyc + dok_d);
            data_rdata_i   = data_data_ok_i ? rd : $urandom;
            #1;
            checks++;
            if (data_req_o !== (memv && !accepted)) begin
                errors++; $display("FAIL req op=%0d cyc=%0d got %b exp %b", op, cyc, data_req_o, memv && !accepted);
            end
            if (memv && !accepted) begin
                checks++;
                if ({data_addr_o, data_wr_o, data_size_o, data_wstrb_o} !== {addr, stv, m_size(op), m_strb(op, addr)}) begin
                    errors++; $display("FAIL bus_fields op=%0d got addr=%h wr=%b size=%0d strb=%b exp addr=%h wr=%b size=%0d strb=%b",
                                       op, data_addr_o, data_wr_o, data_size_o, data_wstrb_o, addr, stv, m_size(op), m_strb(op, addr));
                end
                if (stv) begin
                    checks++;
                    if (data_wdata_o !== m_wdata(op, st)) begin
                        errors++; $display("FAIL store_wdata op=%0d got %h exp %h", op, data_wdata_o, m_wdata(op, st));
                    end
                end
            end
            if (!memv) begin
                checks++;
                if (mm_stallreq_o !== 1'b0) begin errors++; $display("FAIL stallreq_none got %b exp 0", mm_stallreq_o); end
                done = 1;
            end else if (data_data_ok_i) begin
                checks++;
                if ({mm_stallreq_o, mm_nofwd_o, mm_wdata_bp_o} !== {1'b0, nf, exp_wd}) begin
                    errors++; $display("FAIL resp_cycle op=%0d got stallreq=%b nofwd=%b bp=%h exp 0 %b %h",
                                       op, mm_stallreq_o, mm_nofwd_o, mm_wdata_bp_o, nf, exp_wd);
                end
                done = 1;
            end else begin
                checks++;
                if ({mm_stallreq_o, mm_nofwd_o} !== {1'b1, nf | ld}) begin
                    errors++; $display("FAIL pending op=%0d cyc=%0d got stallreq=%b nofwd=%b exp 1 %b",
                                       op, cyc, mm_stallreq_o, mm_nofwd_o, nf | ld);
                end
            end
            if (data_req_o && data_addr_ok_i) begin accepted = 1; acc_cyc = cyc; nreq++; end
            @(posedge clk); #1;
            cyc++;
        end
        data_addr_ok_i = 1'b0; data_data_ok_i = 1'b0;
        checks++;
        if (!done) begin
            errors++; $display("FAIL timeout op=%0d got no response exp completion", op);
        end else if ({wb_wren_o, wb_waddr_o, wb_wdata_o, wb_inst_o, wb_inslot_o, mm_excp_o} !==
                     {exp_wren, wa, exp_wd, inst, slot, 1'b0}) begin
            errors++; $display("FAIL wb_regs op=%0d got wren=%b waddr=%0d wdata=%h inst=%h slot=%b excp=%b exp %b %0d %h %h %b 0",
                               op, wb_wren_o, wb_waddr_o, wb_wdata_o, wb_inst_o, wb_inslot_o, mm_excp_o,
                               exp_wren, wa, exp_wd, inst, slot);
        end
        checks++;
        if (nreq != (memv ? 1 : 0)) begin
            errors++; $display("FAIL txn_count op=%0d got %0d exp %0d", op, nreq, memv ? 1 : 0);
        end
    endtask

    task automatic idle_inputs();
        mm_memop_i = 4'd0; mm_flush_i = 1'b0; ext_stall = 1'b0; mm_wren_i = 1'b0; mm_waddr_i = 5'd0;
        mm_wdata_i = 32'd0; mm_stdata_i = 32'd0; mm_inst_i = 32'd0; mm_inslot_i = 1'b0; mm_nofwd_i = 1'b0;
        data_addr_ok_i = 1'b0; data_data_ok_i = 1'b0; data_rdata_i = 32'd0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({wb_wren_o, wb_waddr_o, wb_wdata_o, wb_inst_o, wb_inslot_o, mm_excp_o, data_req_o, mm_stallreq_o} !== 72'd0) begin
            errors++; $display("FAIL reset_state got wren=%b waddr=%0d wdata=%h inst=%h slot=%b excp=%b req=%b stallreq=%b exp all 0",
                               wb_wren_o, wb_waddr_o, wb_wdata_o, wb_inst_o, wb_inslot_o, mm_excp_o, data_req_o, mm_stallreq_o);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_loads();
        logic [3:0]  ops [4] = '{4'd5, 4'd1, 4'd2, 4'd3};
        logic [31:0] adr [4] = '{32'h100, 32'h103, 32'h103, 32'h102};
        logic [31:0] rdv [4] = '{32'hDEAD_BEEF, 32'h80FF_FF12, 32'h80FF_FF12, 32'h80FF_FF12};
        logic [31:0] exv [4] = '{32'hDEAD_BEEF, 32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF};
        for (int i = 0; i < 4; i++) begin
            run_op(ops[i], adr[i], 32'd0, rdv[i], 0, 1);
            checks++;
            if (wb_wdata_o !== exv[i]) begin
                errors++; $display("FAIL load_value idx=%0d got %h exp %h", i, wb_wdata_o, exv[i]);
            end
        end
    endtask

    task automatic test_store();
        mm_memop_i = 4'd7; mm_wdata_i = 32'h202; mm_stdata_i = 32'h1234_ABCD; mm_wren_i = 1'b1;
        #1;
        checks++;
        if ({data_req_o, data_wr_o, data_size_o, data_wstrb_o, data_wdata_o} !== {1'b1, 1'b1, 2'd1, 4'b1100, 32'hABCD_ABCD}) begin
            errors++; $display("FAIL sh_request got req=%b wr=%b size=%0d strb=%b wdata=%h exp 1 1 1 1100 abcdabcd",
                               data_req_o, data_wr_o, data_size_o, data_wstrb_o, data_wdata_o);
        end
        run_op(4'd7, 32'h202, 32'h1234_ABCD, 32'd0, 0, 1);
        checks++;
        if (wb_wren_o !== 1'b0) begin errors++; $display("FAIL sh_wren got %b exp 0", wb_wren_o); end
        run_op(4'd6, 32'h201, 32'h0000_0077, 32'd0, 1, 2);
        run_op(4'd8, 32'h204, 32'h5566_7788, 32'd0, 0, 1);
    endtask

    task automatic test_addr_ok_delay();
        run_op(4'd5, 32'h180, 32'd0, $urandom, 3, 1);
        run_op(4'd8, 32'h184, $urandom, 32'd0, 3, 2);
    endtask

    task automatic test_flush_wait();
        idle_inputs();
        mm_memop_i = 4'd5; mm_wdata_i = 32'h400; mm_wren_i = 1'b1; mm_inst_i = 32'h1111_0000;
        data_addr_ok_i = 1'b1;
        #1;
        checks++;
        if (data_req_o !== 1'b1) begin errors++; $display("FAIL flushw_req0 got %b exp 1", data_req_o); end
        @(posedge clk); #1;
        data_addr_ok_i = 1'b0; mm_flush_i = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({wb_wren_o, wb_wdata_o, wb_inst_o} !== 65'd0) begin
            errors++; $display("FAIL flushw_wb got wren=%b wdata=%h inst=%h exp zeros", wb_wren_o, wb_wdata_o, wb_inst_o);
        end
        mm_flush_i = 1'b0; mm_wdata_i = 32'h500; mm_inst_i = 32'h2222_0000;
        for (int c = 0; c < 2; c++) begin
            data_data_ok_i = (c == 1); data_rdata_i = 32'h1111_1111;
            #1;
            checks++;
            if ({data_req_o, mm_stallreq_o} !== 2'b01) begin
                errors++; $display("FAIL cancel_cyc%0d got req=%b stallreq=%b exp 0 1", c, data_req_o, mm_stallreq_o);
            end
            @(posedge clk); #1;
        end
        data_data_ok_i = 1'b0;
        checks++;
        if (wb_wdata_o !== 32'd0) begin errors++; $display("FAIL cancel_nocapture got %h exp 0", wb_wdata_o); end
        run_op(4'd5, 32'h500, 32'd0, 32'h2233_4455, 0, 1);
    endtask

    task automatic test_stall_done();
        run_op(4'd0, 32'h0000_AAAA, 32'd0, 32'd0, 0, 1);
        mm_memop_i = 4'd5; mm_wdata_i = 32'h300; mm_wren_i = 1'b1; mm_flush_i = 1'b0;
        data_addr_ok_i = 1'b1;
        #1;
        @(posedge clk); #1;
        data_addr_ok_i = 1'b0; data_data_ok_i = 1'b1; data_rdata_i = 32'hCAFE_F00D; ext_stall = 1'b1;
        @(posedge clk); #1;
        data_data_ok_i = 1'b0;
        for (int c = 0; c < 2; c++) begin
            data_rdata_i = $urandom;
            #1;
            checks++;
            if ({data_req_o, mm_stallreq_o, mm_wdata_bp_o, wb_wdata_o} !== {2'b00, 32'hCAFE_F00D, 32'h0000_AAAA}) begin
                errors++; $display("FAIL done_hold%0d got req=%b stallreq=%b bp=%h wb=%h exp 0 0 cafef00d 0000aaaa",
                                   c, data_req_o, mm_stallreq_o, mm_wdata_bp_o, wb_wdata_o);
            end
            @(posedge clk); #1;
        end
        ext_stall = 1'b0;
        #1;
        checks++;
        if (data_req_o !== 1'b0) begin errors++; $display("FAIL done_rerequest got %b exp 0", data_req_o); end
        @(posedge clk); #1;
        checks++;
        if ({wb_wren_o, wb_wdata_o} !== {1'b1, 32'hCAFE_F00D}) begin
            errors++; $display("FAIL done_release got wren=%b wdata=%h exp 1 cafef00d", wb_wren_o, wb_wdata_o);
        end
        mm_memop_i = 4'd0;
    endtask

    task automatic test_flush_req();
        idle_inputs();
        mm_memop_i = 4'd3; mm_wdata_i = 32'h600; mm_wren_i = 1'b1;
        #1;
        @(posedge clk); #1;
        mm_flush_i = 1'b1; data_addr_ok_i = 1'b1;
        #1;
        checks++;
        if (data_req_o !== 1'b0) begin errors++; $display("FAIL flushreq_req got %b exp 0", data_req_o); end
        @(posedge clk); #1;
        checks++;
        if ({wb_wren_o, wb_wdata_o} !== 33'd0) begin
            errors++; $display("FAIL flushreq_wb got wren=%b wdata=%h exp 0 0", wb_wren_o, wb_wdata_o);
        end
        idle_inputs();
        run_op(4'd4, 32'h602, 32'd0, $urandom, 1, 1);
    endtask

    task automatic test_reset_mid();
        idle_inputs();
        mm_memop_i = 4'd5; mm_wdata_i = 32'h700; data_addr_ok_i = 1'b1;
        #1;
        @(posedge clk); #1;
        data_addr_ok_i = 1'b0;
        rst = 1'b1; #2; rst = 1'b0;
        mm_wdata_i = 32'h704; data_data_ok_i = 1'b1; data_rdata_i = 32'h9999_9999;
        #1;
        checks++;
        if ({data_req_o, mm_stallreq_o, wb_wdata_o} !== {2'b11, 32'd0}) begin
            errors++; $display("FAIL reset_mid got req=%b stallreq=%b wb=%h exp 1 1 0", data_req_o, mm_stallreq_o, wb_wdata_o);
        end
        @(posedge clk); #1;
        data_data_ok_i = 1'b0;
        run_op(4'd5, 32'h704, 32'd0, 32'h0BAD_F00D, 0, 2);
    endtask

    task automatic test_random();
        logic [3:0] op;
        for (int i = 0; i < 60; i++) begin
            op = 4'($urandom_range(0, 10));
            if (i % 17 == 16) op = 4'hF;
            run_op(op, $urandom, $urandom, $urandom, $urandom_range(0, 2), $urandom_range(1, 3));
        end
    endtask

    initial begin
        test_reset();
        test_loads();
        test_store();
        test_addr_ok_delay();
        test_flush_wait();
        test_stall_done();
        test_flush_req();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
